// File: rtl/a2d_intf.sv
// rtl/a2d_intf.sv - SPI master that runs a two-frame conversion on an external ADC
module a2d_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        a2d_SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {IDLE, SHIFT, BACK} state_t;

  state_t      state;
  state_t      nxt_state;
  logic [4:0]  sclk_div;
  logic [5:0]  smpl_cnt;
  logic [15:0] shft;
  logic [2:0]  chnnl_lat;
  logic        accept;
  logic        smpl;
  logic        reload;
  logic        done;

  // Next-state and per-cycle strobes; sampling happens on the cycle before SCLK rises
  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    smpl      = 1'b0;
    reload    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (strt_cnv) begin
          accept    = 1'b1;
          nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_div == 5'd15) begin
          smpl = 1'b1;
          // Frame 1 only primes the ADC mux; its returned data is thrown away
          if (smpl_cnt == 6'd15) reload = 1'b1;
          if (smpl_cnt == 6'd31) nxt_state = BACK;
        end
      end
      BACK: begin
        // Hold SS low until late in the final high phase for ADC hold time
        if (sclk_div == 5'd30) begin
          done      = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // SCLK divider and sample counter; the divider starts at 23 so the first fall lands 9 clk after SS
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_div <= 5'd0;
      smpl_cnt <= 6'd0;
    end else if (accept) begin
      sclk_div <= 5'd23;
      smpl_cnt <= 6'd0;
    end else begin
      if (state != IDLE) sclk_div <= sclk_div + 5'd1;
      if (smpl)          smpl_cnt <= smpl_cnt + 6'd1;
    end
  end

  // Command/data shift register, shared between outgoing command and incoming sample bits
  always_ff @(posedge clk) begin
    if (rst) begin
      shft      <= 16'h0000;
      chnnl_lat <= 3'd0;
    end else if (accept) begin
      shft      <= {2'b00, chnnl, 11'h000};
      chnnl_lat <= chnnl;
    end else if (smpl) begin
      if (reload) shft <= {2'b00, chnnl_lat, 11'h000};
      else        shft <= {shft[14:0], MISO};
    end
  end

  // Slave select, sticky completion flag and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a2d_SS_n  <= 1'b1;
      cnv_cmplt <= 1'b0;
      res       <= 12'h000;
    end else if (accept) begin
      a2d_SS_n  <= 1'b0;
      cnv_cmplt <= 1'b0;
    end else if (done) begin
      a2d_SS_n  <= 1'b1;
      cnv_cmplt <= 1'b1;
      res       <= shft[11:0];
    end
  end

  // SCLK parks high whenever no frame is being clocked
  always_comb begin
    SCLK = (state == SHIFT) ? sclk_div[4] : 1'b1;
    MOSI = shft[15];
  end

endmodule
